mem_responder: RTL and testbench
================================

# mem_responder

Bus responder for the 6502 control unit's 16-bit address / 8-bit data bus. Serves CPU read and write cycles to a small on-chip RAM and to one memory-mapped display-digit register, completing each request with a one-cycle `ready` pulse after a programmable number of wait states. Sits beside the ROM on the control unit's bus. Drives the seven-segment encoder's digit input.

## Interface
Parameters:
- `DEPTH`, 256: RAM words. Must be a power of two.
- `RAM_BASE`, 16'h0200: first RAM address. Must be aligned to `DEPTH`.
- `IO_ADDR`, 16'hD000: display-digit register address.
- `WAIT_STATES`, 1: extra cycles before response, 0..15.

Ports:
- `clk_in`, in, 1: sole clock, rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `addr_bus_in`, in, 16: request address.
- `data_bus_in`, in, 8: write data.
- `rw`, in, 1: 1 = read, 0 = write.
- `enable`, in, 1: request valid.
- `data_bus_out`, out, 8: read data.
- `ready`, out, 1: one-cycle completion pulse.
- `hit`, out, 1: completed request decoded to RAM or IO.
- `dgt_out`, out, 4: display digit.

## Operation
- States are IDLE, WAIT and RESP.
- IDLE: on an edge with `enable`=1, latch the address, `rw` and write data.
  - Go to RESP if `WAIT_STATES`=0.
  - Otherwise load the counter with `WAIT_STATES`-1 and go to WAIT.
- WAIT: decrement the counter each cycle. Go to RESP on the edge where the counter is 0.
- The access happens on the edge entering RESP:
  - Read: register the result into `data_bus_out`.
  - Write: commit to RAM or IO.
  - Register `hit` on the same edge.
- RESP: `ready`=1 for exactly one cycle, then go to IDLE unconditionally.
- Address decode uses the latched address.
  - RAM hit: (addr − `RAM_BASE`) mod 2^16 < `DEPTH`. Index is the low log2(`DEPTH`) bits of the difference.
  - IO hit: addr == `IO_ADDR`.
  - No other addresses are claimed.
- Read results:
  - RAM: the stored byte.
  - IO: {4'h0, `dgt_out`}.
  - Unmapped: 8'hFF (open bus), with `hit`=0.
- Write effects:
  - RAM: store the byte.
  - IO: `dgt_out` ← data[3:0]; the upper nibble is ignored.
  - Unmapped: ignored, `hit`=0. The request still completes, so the bus never hangs.
- The initiator holds address, `rw`, data and `enable` stable until it samples `ready`=1. It deasserts `enable` on that same edge unless it is issuing a new request.
- Input changes during WAIT are ignored, because values are latched at accept.

## Timing
- Reset (`reset_n`=0 at an edge):
  - State goes to IDLE.
  - `ready`=0, `hit`=0, `data_bus_out`=8'h00, `dgt_out`=4'h0.
  - The counter clears.
- Reset in mid-transaction: any pending write is discarded and no `ready` is issued. RAM contents are not reset.
- Latency: the accept edge is E0. `ready` is high in the cycle after edge E0+`WAIT_STATES`, i.e. `WAIT_STATES`+1 cycles after accept.
- Throughput: one request per `WAIT_STATES`+2 cycles. If `enable` is high in the cycle after RESP, it is accepted from IDLE immediately.
- `data_bus_out` holds its last read value until the next completed read. Writes do not change it.
- `hit` holds until the next completion.
- Write-then-read of the same address returns the new data with no hazard, because the write commits before RESP.
- RAM is synchronous, written and read only on the RESP-entry edge. A single-port array is sufficient.

## Structure
- Shared bus package holds:
  - `RW_READ`=1 and `RW_WRITE`=0.
  - `OPEN_BUS`=8'hFF.
  - Default map constants `RAM_BASE`, `IO_ADDR` and `ROM_BASE`=16'h0000, shared with the ROM and control unit.
  - State encoding for IDLE, WAIT and RESP.
- Sub-module `mem_addr_decode`:
  - Combinational.
  - Inputs: address.
  - Outputs: `ram_hit`, `io_hit`, `ram_index`.
  - Reused later by the ROM chip-select.

## Test plan
- **Reset values:** hold `reset_n`=0 for 3 cycles, then release. Require all outputs 0 and no `ready` while `enable`=0.
- **RAM write then read:** with `WAIT_STATES`=1, write 8'hA5 to 16'h0210, then read 16'h0210. Require:
  - each `ready` exactly 2 cycles after accept;
  - `data_bus_out`=8'hA5 and `hit`=1 on the read.
- **IO write:** write 8'h3C to 16'hD000. Require `dgt_out`=4'hC after RESP. A following read of 16'hD000 returns 8'h0C.
- **Unmapped and wrap:**
  - Read 16'h0300 (just past RAM). Require 8'hFF and `hit`=0.
  - Read 16'h01FF. Require 8'hFF; the decode must not wrap into RAM.
  - Write to 16'h4000. Require no RAM or IO change.
- **Back-to-back requests:** with `WAIT_STATES`=0, keep `enable` high across 4 reads of 16'h0200..16'h0203. Require a `ready` every 2 cycles with the correct data, and no missed or duplicated pulses.
- **Reset mid-write:** accept a write of 8'h77 to 16'h0205 with `WAIT_STATES`=3, and assert `reset_n`=0 during WAIT. Require:
  - no `ready`;
  - a later read of 16'h0205 returns the prior contents, not 8'h77.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared bus definitions for the 6502 control unit: rw encoding, open-bus value,
// default memory map and the responder state encoding.
package mem_responder_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

  localparam logic [15:0] ROM_BASE = 16'h0000;
  localparam logic [15:0] RAM_BASE = 16'h0200;
  localparam logic [15:0] IO_ADDR  = 16'hD000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bus_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side bus bundle: 16-bit address, 8-bit data, rw/enable request and
// ready/hit completion.
interface mem_responder_if;

  logic [15:0] addr_bus_in;
  logic [7:0]  data_bus_in;
  logic        rw;
  logic        enable;
  logic [7:0]  data_bus_out;
  logic        ready;
  logic        hit;

  modport master (
    output addr_bus_in, data_bus_in, rw, enable,
    input  data_bus_out, ready, hit
  );

  modport slave (
    input  addr_bus_in, data_bus_in, rw, enable,
    output data_bus_out, ready, hit
  );

endinterface

// File: rtl/mem_addr_decode.sv
// Combinational address decode for a DEPTH-word RAM window and a single IO register.
// The RAM window never wraps below RAM_BASE because the compare is on the offset.
module mem_addr_decode #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [15:0] RAM_BASE = mem_responder_pkg::RAM_BASE,
  parameter logic [15:0] IO_ADDR  = mem_responder_pkg::IO_ADDR
) (
  input  logic [15:0]              addr,
  output logic                     ram_hit,
  output logic                     io_hit,
  output logic [$clog2(DEPTH)-1:0] ram_index
);

  logic [15:0] offset;

  always_comb begin
    offset    = addr - RAM_BASE;
    ram_hit   = {1'b0, offset} < 17'(DEPTH);
    io_hit    = (addr == IO_ADDR);
    ram_index = offset[$clog2(DEPTH)-1:0];
  end

endmodule

// File: rtl/mem_responder.sv
// Bus responder: on-chip RAM plus a display-digit register, each request
// completed by a one-cycle ready pulse after WAIT_STATES extra cycles.
module mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter logic [15:0] RAM_BASE    = mem_responder_pkg::RAM_BASE,
  parameter logic [15:0] IO_ADDR     = mem_responder_pkg::IO_ADDR,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk_in,
  input  logic            reset_n,
  mem_responder_if.slave  bus,
  output logic [3:0]      dgt_out
);

  import mem_responder_pkg::*;

  localparam int unsigned IW = $clog2(DEPTH);

  bus_state_t  state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        accept, enter_resp;

  logic [15:0] lat_addr;
  logic        lat_rw;
  logic [7:0]  lat_data;

  logic [15:0] acc_addr;
  logic        acc_rw;
  logic [7:0]  acc_data;

  logic          ram_hit, io_hit;
  logic [IW-1:0] ram_index;

  logic [7:0]  ram [DEPTH];
  logic [7:0]  rdata_q;
  logic        hit_q;
  logic [3:0]  dgt_q;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (bus.enable) begin
        accept = 1'b1;
        if (WAIT_STATES == 0) begin
          state_n    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_n = WAIT;
          cnt_n   = 4'(WAIT_STATES - 1);
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_n    = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_n = cnt - 4'd1;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // With zero wait states the access edge is also the accept edge, so the
  // request is taken straight from the bus while still in IDLE.
  always_comb begin
    acc_addr = (state == IDLE) ? bus.addr_bus_in : lat_addr;
    acc_rw   = (state == IDLE) ? bus.rw          : lat_rw;
    acc_data = (state == IDLE) ? bus.data_bus_in : lat_data;
  end

  mem_addr_decode #(
    .DEPTH    (DEPTH),
    .RAM_BASE (RAM_BASE),
    .IO_ADDR  (IO_ADDR)
  ) u_decode (
    .addr      (acc_addr),
    .ram_hit   (ram_hit),
    .io_hit    (io_hit),
    .ram_index (ram_index)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_rw   <= RW_READ;
      lat_data <= '0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      dgt_q    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        lat_addr <= bus.addr_bus_in;
        lat_rw   <= bus.rw;
        lat_data <= bus.data_bus_in;
      end
      if (enter_resp) begin
        hit_q <= ram_hit | io_hit;
        if (acc_rw == RW_READ) begin
          if (ram_hit)     rdata_q <= ram[ram_index];
          else if (io_hit) rdata_q <= {4'h0, dgt_q};
          else             rdata_q <= OPEN_BUS;
        end else if (io_hit) begin
          dgt_q <= acc_data[3:0];
        end
      end
    end
  end

  // RAM contents survive reset; only the pending write is suppressed.
  always_ff @(posedge clk_in) begin
    if (reset_n && enter_resp && acc_rw == RW_WRITE && ram_hit)
      ram[ram_index] <= acc_data;
  end

  assign bus.data_bus_out = rdata_q;
  assign bus.ready        = (state == RESP);
  assign bus.hit          = hit_q;
  assign dgt_out          = dgt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_STATES 1, 0 and 3
// share one clock; index 0/1/2 selects the instance.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [3];
  logic        en   [3];
  logic        rwv  [3];
  logic [15:0] ad   [3];
  logic [7:0]  wd   [3];
  logic [7:0]  rd   [3];
  logic        rdy  [3];
  logic        ht   [3];
  logic [3:0]  dg   [3];

  int tests = 0;
  int fails = 0;

  mem_responder_if b1 ();
  mem_responder_if b0 ();
  mem_responder_if b3 ();

  assign b1.addr_bus_in = ad[0];
  assign b1.data_bus_in = wd[0];
  assign b1.rw          = rwv[0];
  assign b1.enable      = en[0];
  assign rd[0]          = b1.data_bus_out;
  assign rdy[0]         = b1.ready;
  assign ht[0]          = b1.hit;

  assign b0.addr_bus_in = ad[1];
  assign b0.data_bus_in = wd[1];
  assign b0.rw          = rwv[1];
  assign b0.enable      = en[1];
  assign rd[1]          = b0.data_bus_out;
  assign rdy[1]         = b0.ready;
  assign ht[1]          = b0.hit;

  assign b3.addr_bus_in = ad[2];
  assign b3.data_bus_in = wd[2];
  assign b3.rw          = rwv[2];
  assign b3.enable      = en[2];
  assign rd[2]          = b3.data_bus_out;
  assign rdy[2]         = b3.ready;
  assign ht[2]          = b3.hit;

  mem_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk_in(clk), .reset_n(rstn[0]), .bus(b1), .dgt_out(dg[0]));
  mem_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk_in(clk), .reset_n(rstn[1]), .bus(b0), .dgt_out(dg[1]));
  mem_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk_in(clk), .reset_n(rstn[2]), .bus(b3), .dgt_out(dg[2]));

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure cycles until ready, return the response and
  // check that ready drops after exactly one cycle.
  task automatic xfer(input int d, input logic r, input logic [15:0] a,
                      input logic [7:0] w, input string tag,
                      output logic [7:0] q, output logic h);
    int n;
    bit seen;
    ad[d] = a; rwv[d] = r; wd[d] = w; en[d] = 1'b1;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (rdy[d] === 1'b1) seen = 1;
    end
    en[d] = 1'b0;
    chk({tag, " latency"}, 16'(n), 16'(ws_of(d) + 1));
    q = rd[d];
    h = ht[d];
    @(posedge clk); #1;
    chk({tag, " pulse width"}, 16'(rdy[d]), 16'h0);
  endtask

  logic [7:0] q;
  logic       h;
  logic [7:0] bb [4];
  int         k;

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bb = '{8'h10, 8'h21, 8'h32, 8'h43};
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0; en[i] = 1'b0; rwv[i] = 1'b1; ad[i] = '0; wd[i] = '0;
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset data", 16'(rd[i]),  16'h0);
      chk("reset hit",  16'(ht[i]),  16'h0);
      chk("reset dgt",  16'(dg[i]),  16'h0);
      chk("reset rdy",  16'(rdy[i]), 16'h0);
      rstn[i] = 1'b1;
    end
    repeat (3) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) chk("idle no ready", 16'(rdy[i]), 16'h0);
    end

    // WAIT_STATES=1: RAM, IO, unmapped, boundaries
    xfer(0, 1'b0, 16'h0210, 8'hA5, "ram wr 0210", q, h);
    chk("ram wr hit", 16'(h), 16'h1);
    xfer(0, 1'b1, 16'h0210, 8'h00, "ram rd 0210", q, h);
    chk("ram rd data", 16'(q), 16'h00A5);
    chk("ram rd hit",  16'(h), 16'h1);
    xfer(0, 1'b0, 16'h0200, 8'h33, "ram wr 0200", q, h);
    xfer(0, 1'b0, 16'hD000, 8'h3C, "io wr", q, h);
    chk("io wr hit", 16'(h), 16'h1);
    chk("io dgt",    16'(dg[0]), 16'h000C);
    chk("io wr keeps data_out", 16'(rd[0]), 16'h00A5);
    xfer(0, 1'b1, 16'hD000, 8'h00, "io rd", q, h);
    chk("io rd data", 16'(q), 16'h000C);
    chk("io rd hit",  16'(h), 16'h1);
    xfer(0, 1'b1, 16'h0300, 8'h00, "rd 0300", q, h);
    chk("rd 0300 data", 16'(q), 16'h00FF);
    chk("rd 0300 hit",  16'(h), 16'h0);
    xfer(0, 1'b1, 16'h01FF, 8'h00, "rd 01FF", q, h);
    chk("rd 01FF data", 16'(q), 16'h00FF);
    chk("rd 01FF hit",  16'(h), 16'h0);
    xfer(0, 1'b0, 16'h4000, 8'h5A, "wr 4000", q, h);
    chk("wr 4000 hit", 16'(h), 16'h0);
    chk("wr 4000 dgt", 16'(dg[0]), 16'h000C);
    chk("wr 4000 keeps data_out", 16'(rd[0]), 16'h00FF);
    xfer(0, 1'b1, 16'h0200, 8'h00, "rd 0200 after 4000", q, h);
    chk("ram 0200 unchanged", 16'(q), 16'h0033);
    xfer(0, 1'b1, 16'h0210, 8'h00, "rd 0210 again", q, h);
    chk("ram 0210 unchanged", 16'(q), 16'h00A5);
    xfer(0, 1'b0, 16'h02FF, 8'h96, "wr 02FF", q, h);
    xfer(0, 1'b1, 16'h02FF, 8'h00, "rd 02FF", q, h);
    chk("ram top data", 16'(q), 16'h0096);
    chk("ram top hit",  16'(h), 16'h1);

    // WAIT_STATES=0: preload, then back-to-back reads with enable held high
    for (int i = 0; i < 4; i++)
      xfer(1, 1'b0, 16'h0200 + 16'(i), bb[i], "ws0 preload", q, h);
    ad[1] = 16'h0200; rwv[1] = 1'b1; en[1] = 1'b1; k = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      chk("b2b ready", 16'(rdy[1]), 16'((n % 2 == 1) && (n <= 7)));
      if (rdy[1] === 1'b1 && k < 4) begin
        chk("b2b data", 16'(rd[1]), 16'(bb[k]));
        chk("b2b hit",  16'(ht[1]), 16'h1);
        k++;
        if (k < 4) ad[1] = 16'h0200 + 16'(k);
        else       en[1] = 1'b0;
      end
    end
    en[1] = 1'b0;
    chk("b2b pulse count", 16'(k), 16'd4);
    repeat (2) @(posedge clk);
    #1;

    // WAIT_STATES=3: reset during WAIT discards the write
    xfer(2, 1'b0, 16'h0205, 8'h11, "ws3 wr 0205", q, h);
    ad[2] = 16'h0205; wd[2] = 8'h77; rwv[2] = 1'b0; en[2] = 1'b1;
    @(posedge clk); #1;
    chk("midrst ready after accept", 16'(rdy[2]), 16'h0);
    @(posedge clk); #1;
    chk("midrst ready in wait", 16'(rdy[2]), 16'h0);
    rstn[2] = 1'b0; en[2] = 1'b0;
    @(posedge clk); #1;
    chk("midrst ready in reset", 16'(rdy[2]), 16'h0);
    chk("midrst hit cleared",    16'(ht[2]),  16'h0);
    chk("midrst data cleared",   16'(rd[2]),  16'h0);
    rstn[2] = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst no ready", 16'(rdy[2]), 16'h0);
    end
    xfer(2, 1'b1, 16'h0205, 8'h00, "ws3 rd 0205", q, h);
    chk("midrst ram kept", 16'(q), 16'h0011);
    chk("midrst rd hit",   16'(h), 16'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
